// File: rtl/axis_mux_pkg.sv
// Shared definitions for the packet-aware AXI-Stream multiplexer.
//   SEL_EN   : bit position of the enable flag in an 8-bit bus_sel code
//   SEL_NONE : "no channel requested" code
//   SEL_BASE : enable flag alone; SEL_BASE | i requests channel i
//   mux_state_e : selection FSM states
package axis_mux_pkg;

  localparam int unsigned SEL_EN   = 7;
  localparam logic [7:0]  SEL_NONE = 8'h00;
  localparam logic [7:0]  SEL_BASE = 8'h80;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPass = 1'b1
  } mux_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered stream slice: an output register plus one skid register.
// Gives full throughput with registered valid/data, and an input ready that comes
// straight from a flop (not from out_ready_i).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   in_valid_i    : beat offered; caller must only assert it while in_ready_o is high
//   in_ready_o    : skid register empty
//   in_data_i     : beat payload
//   out_valid_o   : output register holds a beat
//   out_ready_i   : downstream ready
//   out_data_o    : output register payload
module axis_skid_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              drain;

  assign drain = out_valid_q && out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (drain) begin
      out_valid_d = 1'b0;
    end
    if (skid_valid_q) begin
      // Input is blocked while the skid holds a beat, so only a reload can happen.
      if (drain) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/axis_pkt_mux.sv
// Packet-aware N:1 AXI-Stream multiplexer. A channel is latched from bus_sel while
// idle and held until that channel's tlast beat is accepted, so packets never
// interleave. Output goes through a two-entry skid slice (registered m_*).
//   clk, rst          : clock, synchronous active-high reset
//   bus_sel           : {enable, channel index}; ignored unless enabled and in range
//   s_tvalid/s_tready : per-channel handshake; only the latched channel sees ready
//   s_tdata/s_tkeep   : channel i at [i*W +: W]
//   s_tlast           : per-channel last
//   m_t*              : registered output stream
//   busy              : a packet is being passed
//   cur_ch            : latched channel index
//   pkt_cnt           : packets completed at the output (wraps)
module axis_pkt_mux
  import axis_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned SEL_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         bus_sel,
  input  logic [N_CH-1:0]          s_tvalid,
  output logic [N_CH-1:0]          s_tready,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH*KEEP_W-1:0]   s_tkeep,
  input  logic [N_CH-1:0]          s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tlast,
  output logic                     busy,
  output logic [SEL_W-2:0]         cur_ch,
  output logic [31:0]              pkt_cnt
);

  localparam int unsigned PayW = DATA_W + KEEP_W + 1;
  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;

  mux_state_e       state_q, state_d;
  logic [SEL_W-2:0] cur_ch_q, cur_ch_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;

  logic [SEL_W-2:0]  sel_idx;
  logic              sel_ok;
  logic [ChW-1:0]    ch_idx;
  logic              ch_valid, ch_last;
  logic [DATA_W-1:0] ch_data;
  logic [KEEP_W-1:0] ch_keep;
  logic              buf_ready, pass_rdy, accept;
  logic [PayW-1:0]   out_payload;

  assign sel_idx = bus_sel[SEL_W-2:0];
  assign sel_ok  = bus_sel[SEL_W-1] && (32'(sel_idx) < N_CH);

  // cur_ch_q is always < N_CH, so the low ChW bits address the channel exactly.
  assign ch_idx   = cur_ch_q[ChW-1:0];
  assign ch_valid = s_tvalid[ch_idx];
  assign ch_last  = s_tlast[ch_idx];
  assign ch_data  = s_tdata[ch_idx*DATA_W +: DATA_W];
  assign ch_keep  = s_tkeep[ch_idx*KEEP_W +: KEEP_W];

  // Ready comes from the skid-full flop only, never from m_tready.
  assign pass_rdy = (state_q == StPass) && !rst && buf_ready;
  assign accept   = pass_rdy && ch_valid;

  always_comb begin
    s_tready         = '0;
    s_tready[ch_idx] = pass_rdy;
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    unique case (state_q)
      StIdle: begin
        if (sel_ok) begin
          state_d  = StPass;
          cur_ch_d = sel_idx;
        end
      end
      StPass: begin
        if (accept && ch_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (m_tvalid && m_tready && m_tlast) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_ch_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  axis_skid_buf #(
    .DATA_W(PayW)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (accept),
    .in_ready_o (buf_ready),
    .in_data_i  ({ch_last, ch_keep, ch_data}),
    .out_valid_o(m_tvalid),
    .out_ready_i(m_tready),
    .out_data_o (out_payload)
  );

  assign {m_tlast, m_tkeep, m_tdata} = out_payload;

  assign busy    = (state_q == StPass);
  assign cur_ch  = cur_ch_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_mux.sv
module tb_axis_pkt_mux;
  import axis_mux_pkg::*;

  localparam int unsigned NCh = 16, DW = 32, KW = 4, SW = 8;
  localparam int unsigned PW  = DW + KW + 1;
  localparam int unsigned NCh4 = 4, DW4 = 64, KW4 = 8;
  localparam int unsigned PW4  = DW4 + KW4 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [SW-1:0]     bus_sel;
  logic [NCh-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NCh*DW-1:0] s_tdata;
  logic [NCh*KW-1:0] s_tkeep;
  logic              m_tvalid, m_tlast, busy;
  logic              m_tready = 1'b1;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [SW-2:0]     cur_ch;
  logic [31:0]       pkt_cnt;

  logic [SW-1:0]       bus_sel4;
  logic [NCh4-1:0]     s4_tvalid, s4_tready, s4_tlast;
  logic [NCh4*DW4-1:0] s4_tdata;
  logic [NCh4*KW4-1:0] s4_tkeep;
  logic                m4_tvalid, m4_tlast, busy4;
  logic [DW4-1:0]      m4_tdata;
  logic [KW4-1:0]      m4_tkeep;
  logic [SW-2:0]       cur_ch4;
  logic [31:0]         pkt_cnt4;

  axis_pkt_mux #(.N_CH(NCh), .DATA_W(DW), .KEEP_W(KW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .busy(busy), .cur_ch(cur_ch), .pkt_cnt(pkt_cnt)
  );

  axis_pkt_mux #(.N_CH(NCh4), .DATA_W(DW4), .KEEP_W(KW4), .SEL_W(SW)) dut4 (
    .clk(clk), .rst(rst), .bus_sel(bus_sel4),
    .s_tvalid(s4_tvalid), .s_tready(s4_tready), .s_tdata(s4_tdata), .s_tkeep(s4_tkeep),
    .s_tlast(s4_tlast), .m_tvalid(m4_tvalid), .m_tready(m_tready), .m_tdata(m4_tdata),
    .m_tkeep(m4_tkeep), .m_tlast(m4_tlast), .busy(busy4), .cur_ch(cur_ch4),
    .pkt_cnt(pkt_cnt4)
  );

  logic [PW-1:0]  exp_q[$];
  logic [PW4-1:0] exp4_q[$];
  int unsigned    out_cyc[$];
  int unsigned    cyc = 0;
  int unsigned    acc_cnt = 0;
  int unsigned    pkts_exp = 0;
  int             n_tests = 0, n_fail = 0;
  int             rdy_mode = 0;  // 0: always ready, 1: toggle pattern, 2: stalled
  int             pat_i = 0;
  bit             pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: begin m_tready = pat[pat_i % 6]; pat_i++; end
      default: m_tready = 1'b0;
    endcase
  end

  // Scoreboard monitors plus stall-stability check on the main instance.
  logic          stall_q = 1'b0, rst_q = 1'b0;
  logic [PW-1:0] held_q, e16;
  logic [PW4-1:0] e4;
  always @(negedge clk) begin
    if ((s_tvalid & s_tready) != '0) acc_cnt++;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected beat", 1, 0);
      else begin
        e16 = exp_q.pop_front();
        check("beat", {m_tlast, m_tkeep, m_tdata}, e16);
        out_cyc.push_back(cyc);
      end
    end
    if (m4_tvalid && m_tready) begin
      if (exp4_q.size() == 0) check("dut4 unexpected beat", 1, 0);
      else begin
        e4 = exp4_q.pop_front();
        check("dut4 beat", {m4_tlast, m4_tkeep, m4_tdata}, e4);
      end
    end
    if (stall_q && !rst_q) begin
      check("stall valid", m_tvalid, 1);
      check("stall hold", {m_tlast, m_tkeep, m_tdata}, held_q);
    end
    stall_q = m_tvalid && !m_tready;
    rst_q   = rst;
    held_q  = {m_tlast, m_tkeep, m_tdata};
  end

  // Called at posedge+1; returns at posedge+1 after the last beat's acceptance edge.
  task automatic send_pkt(input int ch, input int n, input logic [DW-1:0] base,
                          input bit do_sel, input bit push, input bit end_last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l, acc;
    int            t;
    if (do_sel) begin
      bus_sel = SEL_BASE | 8'(ch);
      @(posedge clk); #1;
      bus_sel = SEL_NONE;
    end
    for (int b = 0; b < n; b++) begin
      d = base + DW'(b);
      k = '1;
      k = k >> (b % KW);
      l = end_last && (b == n - 1);
      s_tdata[ch*DW +: DW] = d;
      s_tkeep[ch*KW +: KW] = k;
      s_tlast[ch]  = l;
      s_tvalid[ch] = 1'b1;
      if (push) exp_q.push_back({l, k, d});
      t = 0;
      do begin
        @(negedge clk); acc = s_tready[ch];
        @(posedge clk); #1; t++;
      end while (!acc && t < 200);
      if (!acc) begin
        check($sformatf("timeout ch%0d", ch), 0, 1);
        s_tvalid[ch] = 1'b0;
        return;
      end
    end
    s_tvalid[ch] = 1'b0;
    s_tlast[ch]  = 1'b0;
  endtask

  task automatic send4(input int ch, input int n, input logic [DW4-1:0] base);
    logic [DW4-1:0] d;
    logic [KW4-1:0] k;
    logic           l, acc;
    int             t;
    bus_sel4 = SEL_BASE | 8'(ch);
    @(posedge clk); #1;
    bus_sel4 = SEL_NONE;
    for (int b = 0; b < n; b++) begin
      d = base + DW4'(b);
      k = '1;
      k = k >> b;
      l = (b == n - 1);
      s4_tdata[ch*DW4 +: DW4] = d;
      s4_tkeep[ch*KW4 +: KW4] = k;
      s4_tlast[ch]  = l;
      s4_tvalid[ch] = 1'b1;
      exp4_q.push_back({l, k, d});
      t = 0;
      do begin
        @(negedge clk); acc = s4_tready[ch];
        @(posedge clk); #1; t++;
      end while (!acc && t < 200);
      if (!acc) begin
        check("dut4 timeout", 0, 1);
        s4_tvalid[ch] = 1'b0;
        return;
      end
    end
    s4_tvalid[ch] = 1'b0;
    s4_tlast[ch]  = 1'b0;
  endtask

  task automatic drain_all();
    int t = 0;
    @(posedge clk);
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain", exp_q.size(), 0);
    check("dut4 drain", exp4_q.size(), 0);
  endtask

  logic [7:0] bad_sel[3] = '{8'h00, 8'h90, 8'h7F};
  bit         ch2_done;

  initial begin
    rst = 1'b1; bus_sel = SEL_NONE; bus_sel4 = SEL_NONE;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
    s4_tvalid = '0; s4_tlast = '0; s4_tdata = '0; s4_tkeep = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst m_tvalid", m_tvalid, 0);
    check("rst m_tdata", m_tdata, 0);
    check("rst m_tkeep", m_tkeep, 0);
    check("rst m_tlast", m_tlast, 0);
    check("rst s_tready", s_tready, 0);
    check("rst busy", busy, 0);
    check("rst cur_ch", cur_ch, 0);
    check("rst pkt_cnt", pkt_cnt, 0);
    @(posedge clk); #1;

    // Invalid selects: nothing may happen even with every channel valid.
    s_tvalid = '1;
    for (int i = 0; i < 3; i++) begin
      bus_sel = bad_sel[i];
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("bad sel %0h busy", bad_sel[i]), busy, 0);
      check($sformatf("bad sel %0h s_tready", bad_sel[i]), s_tready, 0);
      check($sformatf("bad sel %0h m_tvalid", bad_sel[i]), m_tvalid, 0);
      @(posedge clk); #1;
    end
    bus_sel = SEL_NONE; s_tvalid = '0;

    // Basic pass-through on channel 3.
    out_cyc.delete();
    send_pkt(3, 4, 32'hA0, 1, 1, 1);
    @(negedge clk);
    check("basic busy after tlast", busy, 0);
    check("basic cur_ch", cur_ch, 3);
    @(posedge clk); #1;
    drain_all();
    pkts_exp++;
    check("basic pkt_cnt", pkt_cnt, pkts_exp);
    check("basic beats", out_cyc.size(), 4);
    if (out_cyc.size() == 4) check("basic back-to-back", out_cyc[3] - out_cyc[0], 3);

    // Selection lock: bus_sel moves to channel 5 mid-packet on channel 2.
    s_tdata[5*DW +: DW] = 32'h50; s_tkeep[5*KW +: KW] = 4'hF; s_tlast[5] = 1'b0;
    s_tvalid[5] = 1'b1;
    out_cyc.delete();
    ch2_done = 1'b0;
    fork
      begin send_pkt(2, 6, 32'h20, 1, 1, 1); ch2_done = 1'b1; end
      begin repeat (3) @(posedge clk); #1 bus_sel = SEL_BASE | 8'd5; end
      begin
        while (!ch2_done) begin
          @(negedge clk);
          if (!ch2_done) check("lock s_tready[5]", s_tready[5], 0);
        end
      end
    join
    fork
      send_pkt(5, 3, 32'h50, 0, 1, 1);
      begin @(posedge clk); #1 bus_sel = SEL_NONE; end
    join
    drain_all();
    pkts_exp += 2;
    check("lock pkt_cnt", pkt_cnt, pkts_exp);
    check("lock beats", out_cyc.size(), 9);
    if (out_cyc.size() == 9) check("lock idle gap", out_cyc[6] - out_cyc[5], 2);

    // Backpressure with toggling m_tready.
    rdy_mode = 1;
    send_pkt(1, 8, 32'h10, 1, 1, 1);
    rdy_mode = 0;
    drain_all();
    pkts_exp++;
    check("bp pkt_cnt", pkt_cnt, pkts_exp);

    // Held stall: out + skid fill, then ready must stay low.
    rdy_mode = 2;
    @(posedge clk); #1;
    acc_cnt = 0;
    fork
      send_pkt(0, 4, 32'h40, 1, 1, 1);
      begin
        repeat (8) @(negedge clk);
        #1;
        check("skid accepts", acc_cnt, 2);
        check("skid full s_tready", s_tready[0], 0);
        check("skid full m_tvalid", m_tvalid, 1);
        @(posedge clk); #1 rdy_mode = 0;
      end
    join
    drain_all();
    pkts_exp++;
    check("skid pkt_cnt", pkt_cnt, pkts_exp);

    // Reset mid-packet with two beats buffered.
    rdy_mode = 2;
    @(posedge clk); #1;
    send_pkt(6, 2, 32'h60, 1, 0, 0);
    s_tdata[6*DW +: DW] = 32'h62; s_tkeep[6*KW +: KW] = 4'h3; s_tvalid[6] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("during rst s_tready", s_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0; rdy_mode = 0;
    @(negedge clk);
    check("post rst m_tvalid", m_tvalid, 0);
    check("post rst m_tdata", m_tdata, 0);
    check("post rst m_tkeep", m_tkeep, 0);
    check("post rst m_tlast", m_tlast, 0);
    check("post rst s_tready", s_tready, 0);
    check("post rst busy", busy, 0);
    check("post rst cur_ch", cur_ch, 0);
    check("post rst pkt_cnt", pkt_cnt, 0);
    pkts_exp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post rst quiet", {busy, m_tvalid}, 0);
    end
    @(posedge clk); #1;
    send_pkt(6, 3, 32'h62, 1, 1, 1);
    drain_all();
    pkts_exp++;
    check("rst resume pkt_cnt", pkt_cnt, pkts_exp);

    // Counter wrap.
    @(negedge clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.pkt_cnt_q;
    @(negedge clk);
    check("cnt preset", pkt_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send_pkt(7, 1, 32'h77, 1, 1, 1);
    drain_all();
    check("cnt wrap", pkt_cnt, 0);

    // Second configuration: N_CH=4, DATA_W=64, KEEP_W=8.
    s4_tvalid = '1;
    bus_sel4 = 8'h84;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dut4 bad sel busy", busy4, 0);
    check("dut4 bad sel s_tready", s4_tready, 0);
    check("dut4 bad sel m_tvalid", m4_tvalid, 0);
    @(posedge clk); #1;
    s4_tvalid = '0; bus_sel4 = SEL_NONE;
    send4(2, 3, 64'h1234_5678_0000_0010);
    rdy_mode = 1;
    send4(3, 4, 64'hCAFE_0000_0000_0020);
    send4(0, 1, 64'h0BAD_F00D_0000_0030);
    rdy_mode = 0;
    drain_all();
    check("dut4 pkt_cnt", pkt_cnt4, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axis_pkt_mux.md
# axis_pkt_mux

Parametrised, packet-aware N:1 AXI-Stream multiplexer with backpressure and a registered output. It replaces the combinational per-beat bus_sel mux in the FIFO-draining path. The selection is latched at a packet boundary and held until the selected channel delivers tlast, so packets are never interleaved. The output stage is a two-entry skid buffer, which gives full throughput with registered tvalid, tdata, tkeep and tlast.

## Interface
- N_CH, 16: number of input channels (2..128).
- DATA_W, 32: tdata width in bits (multiple of 8).
- KEEP_W, DATA_W/8: tkeep width.
- SEL_W, 8: bus_sel width. The MSB is the enable; the low SEL_W-1 bits are the channel index.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_sel  in  SEL_W  channel request; code 0x80+i selects channel i; 0x00 means none.
- s_tvalid  in  N_CH  per-channel valid.
- s_tready  out  N_CH  per-channel ready.
- s_tdata  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_tkeep  in  N_CH*KEEP_W  packed the same way as s_tdata.
- s_tlast  in  N_CH  per-channel last.
- m_tvalid  out  1  output valid (registered).
- m_tready  in  1  downstream ready.
- m_tdata  out  DATA_W  output data (registered).
- m_tkeep  out  KEEP_W  output keep (registered).
- m_tlast  out  1  output last (registered).
- busy  out  1  high while the FSM is in PASS.
- cur_ch  out  SEL_W-1  latched channel index.
- pkt_cnt  out  32  count of packets completed at the output.

## Operation
- sel_ok = bus_sel[SEL_W-1] && bus_sel[SEL_W-2:0] < N_CH. Out-of-range or disabled codes are ignored.
- FSM states are IDLE and PASS. Reset enters IDLE.
- IDLE → PASS when sel_ok is high. The FSM latches cur_ch = bus_sel[SEL_W-2:0]. No beat is accepted in the IDLE cycle.
- PASS → IDLE on an accepted input beat (s_tvalid[cur_ch] && s_tready[cur_ch]) that has s_tlast[cur_ch]=1.
- In PASS, changes to bus_sel are ignored. The new selection takes effect only after the FSM returns to IDLE.
- s_tready[cur_ch] = (state==PASS) && !skid_full. All other s_tready bits are 0, and all bits are 0 in IDLE.
- Skid buffer holds an output register plus one skid register.
  - An accepted beat goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output drains, it reloads from the skid register when that register is full.
  - Beat order is preserved, and data/keep/last are never modified.
- Beats that do not arrive with the selected valid are not consumed. Unselected channels keep their data.
- pkt_cnt increments on m_tvalid && m_tready && m_tlast and wraps from 2^32-1 to 0.
- Zero-length packets do not exist. A single beat with tlast=1 is a complete packet.

## Timing
- Reset values:
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - s_tready=0, busy=0, cur_ch=0, pkt_cnt=0.
  - skid empty, state IDLE.
- Latency:
  - An input beat accepted in cycle t is visible on m_* in cycle t+1 if the output register is empty or draining.
  - Per-packet overhead is one IDLE cycle between packets.
- Throughput: 1 beat/cycle in steady state while m_tready=1.
- Handshake rules:
  - m_tvalid, once high, stays high and m_* stay stable until m_tready.
  - m_tvalid does not depend combinationally on s_* signals.
  - s_tready does not depend combinationally on m_tready; it is derived only from the skid-full register.
- When the skid buffer is full, s_tready drops the next cycle and no beat is lost.
- If the tlast beat is accepted in the same cycle bus_sel changes, the FSM goes to IDLE. The new bus_sel is sampled in IDLE on the following cycle.
- rst asserted mid-packet:
  - All state clears on the next edge and buffered beats are discarded.
  - s_tready is 0 during reset.
  - The remainder of the packet is accepted only after a new selection.

## Structure
- A shared package axis_mux_pkg holds:
  - the SEL_EN bit position,
  - sel code constants (SEL_NONE = 0, SEL_BASE = 0x80),
  - the state enum {IDLE, PASS}.
- Sub-module axis_skid_buf, parametrised on DATA_W: the two-entry output register slice, reusable elsewhere in the stream path.
- The top level contains the FSM, channel extraction by indexed part-select, ready fan-out and the packet counter.

## Test plan
- Basic pass-through:
  - Stimulus: N_CH=16, bus_sel=0x83, channel 3 sends 4 beats 0xA0..0xA3 with tlast on the last beat, m_tready=1.
  - Required: m_tdata shows 0xA0..0xA3 on consecutive cycles, m_tlast on 0xA3, pkt_cnt=1, busy falls after the tlast acceptance.
- Selection lock:
  - Stimulus: bus_sel switches 0x82→0x85 in the middle of a 6-beat packet on channel 2.
  - Required: all 6 beats come from channel 2; s_tready[5]=0 until channel 2's tlast; the channel 5 packet follows after one IDLE cycle.
- Backpressure:
  - Stimulus: m_tready toggles 1,0,0,1,0,1 during an 8-beat burst.
  - Required: no beat is lost or duplicated; s_tready drops the cycle after the skid fills; m_* are stable while stalled.
- Invalid select:
  - Stimulus: bus_sel set to 0x00, 0x90 (index 16 with N_CH=16), and 0x7F.
  - Required: state stays IDLE, all s_tready=0, m_tvalid=0.
- Reset mid-packet:
  - Stimulus: rst asserted for 1 cycle after 2 of 5 beats.
  - Required: all outputs return to reset values next cycle; pkt_cnt=0; nothing is emitted until bus_sel is re-applied.
- Counter wrap and parameter sweep:
  - Stimulus: force pkt_cnt to 0xFFFFFFFF, then complete a packet; rerun the suite with N_CH=4, DATA_W=64.
  - Required: pkt_cnt=0 after the packet; all scenarios pass with KEEP_W=8.
